// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tdm_pkg
// Brief    : Shared types and constants for the 4-channel TDM receiver.
// Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int TDM_CHANNELS = 4;

  localparam logic [1:0] SEL_U = 2'b00;
  localparam logic [1:0] SEL_V = 2'b01;
  localparam logic [1:0] SEL_W = 2'b10;
  localparam logic [1:0] SEL_X = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SLOT = 1'b1
  } tdm_state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_slot_timer
// Brief    : Settle counter plus channel counter; flags the last edge of a slot.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  output logic [1:0] ch,
  output logic       slot_end
);

  localparam logic [3:0] c_settle = 4'(SETTLE);

  logic [3:0] r_cnt;
  logic [1:0] r_ch;

  assign slot_end = enable && (r_cnt == c_settle);
  assign ch       = r_ch;

  // Channel wraps 3 -> 0 on the final slot, which is also the restart point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_ch  <= SEL_U;
    end else if (load) begin
      r_cnt <= 4'd0;
      r_ch  <= SEL_U;
    end else if (slot_end) begin
      r_cnt <= 4'd0;
      r_ch  <= r_ch + 2'd1;
    end else if (enable) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux4
// Brief    : Sequences a 4:1 mux select, samples each channel, and publishes
//            all four values as one coherent frame.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic             GlobalClock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] m,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic [WIDTH-1:0] u,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] x,
  output logic             frame_valid,
  output logic             overrun
);

  tdm_state_t       r_state;
  tdm_state_t       w_next_state;
  logic             w_load;
  logic             w_slot_end;
  logic             w_frame_done;
  logic             w_drop;
  logic             r_start_d;
  logic [1:0]       w_ch;
  logic [WIDTH-1:0] r_shadow [TDM_CHANNELS-1];
  logic [WIDTH-1:0] r_u;
  logic [WIDTH-1:0] r_v;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] r_x;
  logic             r_frame_valid;
  logic             r_overrun;

  tdm_slot_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk      (GlobalClock),
    .rst_n    (resetn),
    .load     (w_load),
    .enable   (r_state == SLOT),
    .ch       (w_ch),
    .slot_end (w_slot_end)
  );

  assign w_frame_done = (r_state == SLOT) && w_slot_end && (w_ch == SEL_X);
  // Only a fresh assertion counts as dropped, so a held start never flags overrun.
  assign w_drop       = (r_state == SLOT) && start && !r_start_d && !w_frame_done;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SLOT;
          w_load       = 1'b1;
        end
      end
      SLOT: begin
        if (w_frame_done && !start) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  for (genvar g = 0; g < TDM_CHANNELS - 1; g++) begin : g_shadow
    always_ff @(posedge GlobalClock or negedge resetn) begin
      if (!resetn) begin
        r_shadow[g] <= '0;
      end else if (w_slot_end && (w_ch == 2'(g))) begin
        r_shadow[g] <= m;
      end
    end
  end

  // Channel x is taken straight from m on the completion edge.
  always_ff @(posedge GlobalClock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_start_d     <= 1'b0;
      r_u           <= '0;
      r_v           <= '0;
      r_w           <= '0;
      r_x           <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_start_d     <= start;
      r_frame_valid <= w_frame_done;
      if (w_frame_done) begin
        r_u <= r_shadow[0];
        r_v <= r_shadow[1];
        r_w <= r_shadow[2];
        r_x <= m;
      end
      if (w_load) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign s1          = w_ch[1];
  assign s0          = w_ch[0];
  assign busy        = (r_state == SLOT);
  assign u           = r_u;
  assign v           = r_v;
  assign w           = r_w;
  assign x           = r_x;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire
